// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and default widths for the cache arbiter
//
// Contents:
//   DEF_ADDR_W / DEF_DATA_W / DEF_TAG_W / DEF_TIMEOUT : default parameter values
//   arb_state_t   : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   req_idx_t     : requester index (0 or 1)
//   idx_to_onehot : requester index -> 2-bit one-hot vector

package cache_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_TAG_W   = 28;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef logic req_idx_t;

  function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_picker2.sv
// rtl/rr_picker2.sv - two-way round-robin winner selection
//
// Ports:
//   req   in  2 : level requests, bit0 = requester 0
//   rr    in  1 : requester favoured when both request
//   grant out 2 : one-hot winner, 00 when nobody requests

module rr_picker2
  import cache_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   rr,
  output logic [1:0] grant
);

  // A lone request wins outright; the pointer only breaks ties.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = idx_to_onehot(rr);
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-requester arbiter in front of a single cache lookup port
//
// Ports:
//   clock, reset            in  : single clock, synchronous active-high reset
//   req                     in  2 : level requests (bit0 = requester 0)
//   req_addr0, req_addr1    in  ADDR_W : lookup address per requester
//   gnt                     out 2 : one-cycle one-hot accept pulse (ISSUE)
//   resp_valid              out 2 : one-cycle one-hot response pulse (RESP)
//   resp_hit/data/tag/timeout out : response payload, meaningful with resp_valid
//   search_cache            out 1 : one-cycle lookup start strobe
//   cache_address           out ADDR_W : latched address of the transaction in flight
//   search_done, hit, cache_data, tag_out in : cache lookup result
//   busy                    out 1 : high whenever the FSM is not IDLE

module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        gnt,
  output logic [1:0]        resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_timeout,
  output logic              search_cache,
  output logic [ADDR_W-1:0] cache_address,
  input  logic              search_done,
  input  logic              hit,
  input  logic [DATA_W-1:0] cache_data,
  input  logic [TAG_W-1:0]  tag_out,
  output logic              busy
);

  // The counter only needs to reach TIMEOUT-1: the last WAIT cycle is
  // detected by compare, not by an extra increment.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  req_idx_t          r_rr;
  req_idx_t          r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_resp_hit;
  logic [DATA_W-1:0] r_resp_data;
  logic [TAG_W-1:0]  r_resp_tag;
  logic              r_resp_timeout;

  logic [1:0]        w_pick;
  req_idx_t          w_win_idx;
  logic              w_timeout;
  logic [1:0]        w_gnt;
  logic [1:0]        w_resp_valid;
  logic              w_search;

  rr_picker2 u_picker (
    .req   (req),
    .rr    (r_rr),
    .grant (w_pick)
  );

  assign w_win_idx = w_pick[1];

  // True during the TIMEOUT-th cycle spent in WAIT (counter starts at 0).
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and strobes
  always_comb begin
    w_state_next = r_state;
    w_gnt        = 2'b00;
    w_resp_valid = 2'b00;
    w_search     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_search     = 1'b1;
        w_gnt        = idx_to_onehot(r_owner);
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (search_done || w_timeout) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_resp_valid = idx_to_onehot(r_owner);
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Transaction datapath: owner/address latch, WAIT counter, response
  // payload and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr           <= 1'b0;
      r_owner        <= 1'b0;
      r_addr         <= '0;
      r_cnt          <= '0;
      r_resp_hit     <= 1'b0;
      r_resp_data    <= '0;
      r_resp_tag     <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_owner <= w_win_idx;
            r_addr  <= w_win_idx ? req_addr1 : req_addr0;
          end
        end
        ST_ISSUE: begin
          r_cnt <= '0;
        end
        ST_WAIT: begin
          // A result landing in the final WAIT cycle beats the timeout.
          if (search_done) begin
            r_resp_hit     <= hit;
            r_resp_data    <= cache_data;
            r_resp_tag     <= tag_out;
            r_resp_timeout <= 1'b0;
          end else if (w_timeout) begin
            r_resp_hit     <= 1'b0;
            r_resp_data    <= '0;
            r_resp_tag     <= '0;
            r_resp_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_rr <= ~r_owner;
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt           = w_gnt;
  assign resp_valid    = w_resp_valid;
  assign search_cache  = w_search;
  assign cache_address = r_addr;
  assign resp_hit      = r_resp_hit;
  assign resp_data     = r_resp_data;
  assign resp_tag      = r_resp_tag;
  assign resp_timeout  = r_resp_timeout;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter

module tb_cache_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int TAG_W   = 28;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req = 2'b00;
  logic [ADDR_W-1:0] req_addr0 = '0;
  logic [ADDR_W-1:0] req_addr1 = '0;
  logic [1:0]        gnt;
  logic [1:0]        resp_valid;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_timeout;
  logic              search_cache;
  logic [ADDR_W-1:0] cache_address;
  logic              search_done = 1'b0;
  logic              hit = 1'b0;
  logic [DATA_W-1:0] cache_data = '0;
  logic [TAG_W-1:0]  tag_out = '0;
  logic              busy;

  always #5 clock = ~clock;

  cache_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .req_addr0     (req_addr0),
    .req_addr1     (req_addr1),
    .gnt           (gnt),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_data     (resp_data),
    .resp_tag      (resp_tag),
    .resp_timeout  (resp_timeout),
    .search_cache  (search_cache),
    .cache_address (cache_address),
    .search_done   (search_done),
    .hit           (hit),
    .cache_data    (cache_data),
    .tag_out       (tag_out),
    .busy          (busy)
  );

  typedef struct {
    int                owner;
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              tmo;
    int                keff;
    int                abs_iss;
    int                abs_resp;
  } exp_t;

  typedef struct {
    logic [1:0]        req;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    int                k;
    logic              hit;
    int                first;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   last_search = -100;
  int   last_resp  = 0;
  int   k_cur      = 1;
  logic hit_cur    = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int owner, input logic [ADDR_W-1:0] addr, input logic hit_in,
                              input int k, input int abs_iss, input int abs_resp);
    exp_t e;
    e.owner    = owner;
    e.addr     = addr;
    e.tmo      = (k == 0);
    e.hit      = (k == 0) ? 1'b0 : hit_in;
    e.data     = (k == 0) ? '0 : DATA_W'(addr) * DATA_W'(addr);
    e.tag      = (k == 0) ? '0 : addr[TAG_W-1:0];
    e.keff     = (k == 0) ? TIMEOUT : k;
    e.abs_iss  = abs_iss;
    e.abs_resp = abs_resp;
    return e;
  endfunction

  // Cache model: answers k_cur cycles after the lookup strobe with
  // data = addr*addr, tag = addr; k_cur == 0 means never answer.
  int                done_at = -1;
  logic [ADDR_W-1:0] cap_addr = '0;
  always @(negedge clock) begin
    search_done = 1'b0;
    hit         = 1'($urandom);
    cache_data  = {$urandom, $urandom};
    tag_out     = TAG_W'($urandom);
    if (done_at >= 0 && cyc == done_at) begin
      search_done = 1'b1;
      hit         = hit_cur;
      cache_data  = DATA_W'(cap_addr) * DATA_W'(cap_addr);
      tag_out     = cap_addr[TAG_W-1:0];
      done_at     = -1;
    end
    if (search_cache === 1'b1) begin
      cap_addr = cache_address;
      done_at  = (k_cur > 0) ? cyc + k_cur : -1;
    end
  end

  // Monitor / scoreboard consumer
  exp_t mon_e;
  int   mon_c;
  always @(negedge clock) begin
    if (search_cache === 1'b1) begin
      chk("search_spacing_ge4", 64'(cyc - last_search >= 4), 64'd1);
      last_search = cyc;
      if (sb_q.size() == 0) begin
        chk("search_unexpected", 64'd1, 64'd0);
      end else begin
        chk("gnt_at_issue", 64'(gnt), (sb_q[0].owner == 0) ? 64'd1 : 64'd2);
        chk("issue_addr", 64'(cache_address), 64'(sb_q[0].addr));
        if (sb_q[0].abs_iss >= 0) chk("issue_cycle", 64'(cyc), 64'(sb_q[0].abs_iss));
      end
    end else if (gnt !== 2'b00) begin
      chk("gnt_outside_issue", 64'(gnt), 64'd0);
    end
    if (resp_valid !== 2'b00) begin
      if (sb_q.size() == 0) begin
        chk("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        mon_c = (mon_e.abs_resp >= 0) ? mon_e.abs_resp : last_resp + 3 + mon_e.keff;
        chk("resp_valid", 64'(resp_valid), (mon_e.owner == 0) ? 64'd1 : 64'd2);
        chk("resp_cycle", 64'(cyc), 64'(mon_c));
        chk("resp_hit", 64'(resp_hit), 64'(mon_e.hit));
        chk("resp_data", resp_data, mon_e.data);
        chk("resp_tag", 64'(resp_tag), 64'(mon_e.tag));
        chk("resp_timeout", 64'(resp_timeout), 64'(mon_e.tmo));
        chk("resp_addr_held", 64'(cache_address), 64'(mon_e.addr));
        last_resp = cyc;
      end
    end
  end

  task automatic drain(input string name, input int max_gnts);
    int budget;
    int ngnt;
    budget = 0;
    ngnt   = 0;
    while (sb_q.size() != 0 && budget < 120) begin
      @(negedge clock);
      budget++;
      if (gnt !== 2'b00) ngnt++;
      if (max_gnts == 0) begin
        // Requester drops req at grant and scribbles its address.
        if (gnt[0] === 1'b1) begin req[0] = 1'b0; req_addr0 = 32'hDEAD_0000; end
        if (gnt[1] === 1'b1) begin req[1] = 1'b0; req_addr1 = 32'hDEAD_0001; end
      end else if (ngnt >= max_gnts) begin
        req = 2'b00;
      end
    end
    chk(name, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    req = 2'b00;
    @(negedge clock);
    chk("idle_after_txn", 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int n0;
    int keff;
    @(negedge clock);
    k_cur     = v.k;
    hit_cur   = v.hit;
    req_addr0 = v.a0;
    req_addr1 = v.a1;
    req       = v.req;
    n0        = cyc;
    keff      = (v.k == 0) ? TIMEOUT : v.k;
    sb_q.push_back(mk(v.first, (v.first == 0) ? v.a0 : v.a1, v.hit, v.k, n0 + 1, n0 + 2 + keff));
    if (v.req == 2'b11)
      sb_q.push_back(mk(1 - v.first, (v.first == 0) ? v.a1 : v.a0, v.hit, v.k, -1, -1));
    drain("vec_drain", 0);
  endtask

  int n0;

  initial begin
    // {req, addr0, addr1, k (0 = never answer), hit, first owner}; rr = 0 after reset
    vecs[0] = '{2'b11, 32'd0,   32'd511,   1,  1'b1, 0};  // tie, rr=0 -> 0 then 1; rr ends 0
    vecs[1] = '{2'b01, 32'd255, 32'd0,     2,  1'b1, 0};  // rr -> 1
    vecs[2] = '{2'b10, 32'd0,   32'd1023,  3,  1'b0, 1};  // miss; rr -> 0
    vecs[3] = '{2'b01, 32'd42,  32'd0,     0,  1'b1, 0};  // timeout; rr -> 1
    vecs[4] = '{2'b01, 32'd300, 32'd0,     16, 1'b1, 0};  // done on the timeout cycle; rr -> 1
    vecs[5] = '{2'b11, 32'd7,   32'd9,     1,  1'b1, 1};  // tie, rr=1 -> 1 then 0; rr ends 1
    vecs[6] = '{2'b01, 32'd12345, 32'd0,   4,  1'b1, 0};  // rr -> 1

    repeat (3) @(negedge clock);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_search", 64'(search_cache), 64'd0);
    chk("rst_addr", 64'(cache_address), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_flags", 64'({resp_hit, resp_timeout, resp_tag}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset during WAIT with search_done arriving right after: dropped silently.
    @(negedge clock);
    k_cur     = 2;
    hit_cur   = 1'b1;
    req_addr0 = 32'd77;
    req       = 2'b01;
    n0        = cyc;
    sb_q.push_back(mk(0, 32'd77, 1'b1, 2, n0 + 1, -1));
    @(negedge clock);
    req = 2'b00;
    @(negedge clock);
    chk("mid_busy_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb_q.delete();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_addr", 64'(cache_address), 64'd0);
    chk("mid_rst_resp_data", resp_data, 64'd0);
    repeat (20) @(negedge clock);
    chk("mid_rst_still_idle", 64'(busy), 64'd0);

    // Both requests held continuously: 01,10,01,10 (rr cleared by reset).
    @(negedge clock);
    k_cur     = 1;
    hit_cur   = 1'b1;
    req_addr0 = 32'd10;
    req_addr1 = 32'd20;
    req       = 2'b11;
    n0        = cyc;
    sb_q.push_back(mk(0, 32'd10, 1'b1, 1, n0 + 1, n0 + 3));
    sb_q.push_back(mk(1, 32'd20, 1'b1, 1, -1, -1));
    sb_q.push_back(mk(0, 32'd10, 1'b1, 1, -1, -1));
    sb_q.push_back(mk(1, 32'd20, 1'b1, 1, -1, -1));
    drain("starve_drain", 4);

    repeat (5) @(negedge clock);
    chk("end_queue_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
